// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two data-memory requesters (CPU MEM stage, DMA
// engine), the port arbiter and the single-ported data memory.
interface dmem_port_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 10
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;

  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_idx, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  // Requesters + memory view
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_idx, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: registered owner FSM (IDLE / OWN_CPU / OWN_DMA)
// with round-robin tie-break and a burst cap so neither requester starves.
// The memory mux selects combinationally from the current owner.
module dmem_port_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned IDX_W     = 10,
  parameter int unsigned MAX_BURST = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  dmem_port_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_DMA} state_e;
  typedef enum logic {OWNER_CPU, OWNER_DMA} owner_e;

  state_e            state, state_next;
  owner_e            last_owner, last_owner_next;
  logic [CNT_W-1:0]  burst_cnt, burst_cnt_next;

  logic              own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              cpu_ack_i, dma_ack_i;
  logic              unused_addr_bits;

  // Owner state, burst counter and round-robin history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_owner <= OWNER_DMA;
    end else begin
      state      <= state_next;
      burst_cnt  <= burst_cnt_next;
      last_owner <= last_owner_next;
    end
  end

  // Next owner, burst count and tie-break history
  always_comb begin
    state_next      = state;
    burst_cnt_next  = burst_cnt;
    last_owner_next = last_owner;

    unique case (state)
      IDLE: begin
        if (bus.cpu_req && bus.dma_req)
          state_next = (last_owner == OWNER_DMA) ? OWN_CPU : OWN_DMA;
        else if (bus.cpu_req)
          state_next = OWN_CPU;
        else if (bus.dma_req)
          state_next = OWN_DMA;
      end
      OWN_CPU: begin
        if (!bus.cpu_req)
          state_next = bus.dma_req ? OWN_DMA : IDLE;
        else if (bus.dma_req && burst_cnt == CNT_MAX)
          state_next = OWN_DMA;
      end
      OWN_DMA: begin
        if (!bus.dma_req)
          state_next = bus.cpu_req ? OWN_CPU : IDLE;
        else if (bus.cpu_req && burst_cnt == CNT_MAX)
          state_next = OWN_CPU;
      end
      default: state_next = IDLE;
    endcase

    // Counter only runs while the owner keeps accessing under contention;
    // any owner change (including to/from IDLE) restarts it.
    if (state_next != state) begin
      burst_cnt_next = '0;
    end else if (state == OWN_CPU) begin
      if (!bus.dma_req)
        burst_cnt_next = '0;
      else if (bus.cpu_req && burst_cnt != CNT_MAX)
        burst_cnt_next = burst_cnt + 1'b1;
    end else if (state == OWN_DMA) begin
      if (!bus.cpu_req)
        burst_cnt_next = '0;
      else if (bus.dma_req && burst_cnt != CNT_MAX)
        burst_cnt_next = burst_cnt + 1'b1;
    end else begin
      burst_cnt_next = '0;
    end

    if (state_next == OWN_CPU && state != OWN_CPU)
      last_owner_next = OWNER_CPU;
    else if (state_next == OWN_DMA && state != OWN_DMA)
      last_owner_next = OWNER_DMA;
  end

  // Acks, owner mux to memory and read-data return
  always_comb begin
    cpu_ack_i = 1'b0;
    dma_ack_i = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;

    unique case (state)
      OWN_CPU: begin
        cpu_ack_i = bus.cpu_req;
        own_we    = bus.cpu_we;
        own_addr  = bus.cpu_addr;
        own_wdata = bus.cpu_wdata;
      end
      OWN_DMA: begin
        dma_ack_i = bus.dma_req;
        own_we    = bus.dma_we;
        own_addr  = bus.dma_addr;
        own_wdata = bus.dma_wdata;
      end
      default: ;
    endcase

    bus.cpu_ack   = cpu_ack_i;
    bus.dma_ack   = dma_ack_i;
    bus.cpu_stall = bus.cpu_req & ~cpu_ack_i;
    bus.mem_we    = (cpu_ack_i | dma_ack_i) & own_we;
    bus.mem_re    = (cpu_ack_i | dma_ack_i) & ~own_we;
    bus.mem_idx   = own_addr[IDX_W+1:2];
    bus.mem_wdata = own_wdata;
    bus.cpu_rdata = (cpu_ack_i && !bus.cpu_we) ? bus.mem_rdata : '0;
    bus.dma_rdata = (dma_ack_i && !bus.dma_we) ? bus.mem_rdata : '0;
  end

  // Byte-lane bits and bits above the 4 KiB window are intentionally dropped
  assign unused_addr_bits = ^{own_addr[ADDR_W-1:IDX_W+2], own_addr[1:0]};

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed table-driven bench for dmem_port_arbiter with a behavioural
// single-port memory (combinational read, write at rising edge).
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.DATA_W(32), .ADDR_W(32), .IDX_W(10)) bus ();

  dmem_port_arbiter #(
    .DATA_W(32), .ADDR_W(32), .IDX_W(10), .MAX_BURST(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0] mem [0:1023];
  assign bus.mem_rdata = mem[bus.mem_idx];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_idx] <= bus.mem_wdata;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else passes++;
  endtask

  typedef struct {
    logic        c_req, c_we; logic [31:0] c_addr, c_wd;
    logic        d_req, d_we; logic [31:0] d_addr, d_wd;
    logic        e_cack, e_dack, e_stall, e_we, e_re;
    logic [9:0]  e_idx; logic [31:0] e_crd, e_drd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic cr, logic cw, logic [31:0] ca, logic [31:0] cd,
    logic dr, logic dw, logic [31:0] da, logic [31:0] dd,
    logic ec, logic ed, logic es, logic ew, logic er,
    logic [9:0] ei, logic [31:0] ecr, logic [31:0] edr);
    vec_t v;
    v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wd = cd;
    v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wd = dd;
    v.e_cack = ec; v.e_dack = ed; v.e_stall = es; v.e_we = ew; v.e_re = er;
    v.e_idx = ei; v.e_crd = ecr; v.e_drd = edr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.cpu_req = v.c_req; bus.cpu_we = v.c_we; bus.cpu_addr = v.c_addr; bus.cpu_wdata = v.c_wd;
    bus.dma_req = v.d_req; bus.dma_we = v.d_we; bus.dma_addr = v.d_addr; bus.dma_wdata = v.d_wd;
  endtask

  task automatic idle_inputs();
    drive(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    idle_inputs();

    // CPU-only write then reads (aligned and misaligned)
    vecs.push_back(mk(1,1,32'h10,32'hDEADBEEF, 0,0,0,0,          0,0,1,0,0, 0,0,0));
    vecs.push_back(mk(1,1,32'h10,32'hDEADBEEF, 0,0,0,0,          1,0,0,1,0, 4,0,0));
    vecs.push_back(mk(1,0,32'h10,0,            0,0,0,0,          1,0,0,0,1, 4,32'hDEADBEEF,0));
    vecs.push_back(mk(1,0,32'h13,0,            0,0,0,0,          1,0,0,0,1, 4,32'hDEADBEEF,0));
    vecs.push_back(mk(0,0,0,0,                 0,0,0,0,          0,0,0,0,0, 0,0,0));
    // DMA-only write with 4 KiB wrap, then read back
    vecs.push_back(mk(0,0,0,0, 1,1,32'h1004,32'h12345678,        0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,1,32'h1004,32'h12345678,        0,1,0,1,0, 1,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0,32'h4,0,                      0,1,0,0,1, 1,0,32'h12345678));
    vecs.push_back(mk(0,0,0,0,                 0,0,0,0,          0,0,0,0,0, 0,0,0));
    // Contention from IDLE after DMA last owned: CPU wins, bursts of 4
    vecs.push_back(mk(1,0,32'h10,0, 1,0,32'h4,0,                 0,0,1,0,0, 0,0,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,0,32'h10,0, 1,0,32'h4,0,               1,0,0,0,1, 4,32'hDEADBEEF,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,0,32'h10,0, 1,0,32'h4,0,               0,1,1,0,1, 1,0,32'h12345678));
    vecs.push_back(mk(1,0,32'h10,0, 1,0,32'h4,0,                 1,0,0,0,1, 4,32'hDEADBEEF,0));
    vecs.push_back(mk(0,0,0,0,                 0,0,0,0,          0,0,0,0,0, 0,0,0));
    // Tie from IDLE after CPU last owned: DMA wins
    vecs.push_back(mk(1,0,32'h10,0, 1,0,32'h4,0,                 0,0,1,0,0, 0,0,0));
    vecs.push_back(mk(1,0,32'h10,0, 1,0,32'h4,0,                 0,1,1,0,1, 1,0,32'h12345678));
    // DMA drops: handover cycle performs no access
    vecs.push_back(mk(1,0,32'h10,0, 0,0,0,0,                     0,0,1,0,0, 0,0,0));
    vecs.push_back(mk(1,0,32'h10,0, 0,0,0,0,                     1,0,0,0,1, 4,32'hDEADBEEF,0));
    vecs.push_back(mk(1,1,32'h20,32'hA5A5A5A5, 1,1,32'h40,32'h0BADF00D, 1,0,0,1,0, 8,0,0));
    vecs.push_back(mk(0,0,0,0, 1,1,32'h40,32'h0BADF00D,          0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,1,32'h40,32'h0BADF00D,          0,1,0,1,0, 16,0,0));
    vecs.push_back(mk(0,0,0,0,                 0,0,0,0,          0,0,0,0,0, 0,0,0));

    // Reset held with both requests high
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h10;
    bus.dma_req = 1'b1; bus.dma_addr = 32'h4;
    repeat (2) @(negedge clk);
    chk("rst cpu_ack", 32'(bus.cpu_ack), 0);
    chk("rst dma_ack", 32'(bus.dma_ack), 0);
    chk("rst mem_we",  32'(bus.mem_we), 0);
    chk("rst mem_re",  32'(bus.mem_re), 0);
    chk("rst mem_idx", 32'(bus.mem_idx), 0);
    rst_n = 1'b1;
    #1;
    chk("rel cycle1 cpu_ack", 32'(bus.cpu_ack), 0);
    @(negedge clk);
    chk("rel cycle2 cpu_ack", 32'(bus.cpu_ack), 1);
    chk("rel cycle2 dma_ack", 32'(bus.dma_ack), 0);

    // Fresh reset with no requests so the table starts in IDLE, DMA last
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1 drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d cpu_ack", i),   32'(bus.cpu_ack),   32'(vecs[i].e_cack));
      chk($sformatf("v%0d dma_ack", i),   32'(bus.dma_ack),   32'(vecs[i].e_dack));
      chk($sformatf("v%0d cpu_stall", i), 32'(bus.cpu_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d mem_we", i),    32'(bus.mem_we),    32'(vecs[i].e_we));
      chk($sformatf("v%0d mem_re", i),    32'(bus.mem_re),    32'(vecs[i].e_re));
      chk($sformatf("v%0d mem_idx", i),   32'(bus.mem_idx),   32'(vecs[i].e_idx));
      chk($sformatf("v%0d cpu_rdata", i), bus.cpu_rdata,      vecs[i].e_crd);
      chk($sformatf("v%0d dma_rdata", i), bus.dma_rdata,      vecs[i].e_drd);
    end

    // Memory contents written through the arbiter
    @(posedge clk);
    #1 idle_inputs();
    chk("mem[4]",  mem[4],  32'hDEADBEEF);
    chk("mem[1]",  mem[1],  32'h12345678);
    chk("mem[8]",  mem[8],  32'hA5A5A5A5);
    chk("mem[16]", mem[16], 32'h0BADF00D);

    // Async reset in the middle of a DMA write
    @(posedge clk);
    #1 drive(mk(0,0,0,0, 1,1,32'h80,32'hCAFEF00D, 0,0,0,0,0, 0,0,0));
    @(negedge clk);
    chk("arst idle mem_we", 32'(bus.mem_we), 0);
    @(negedge clk);
    chk("arst own mem_we",  32'(bus.mem_we), 1);
    chk("arst own mem_idx", 32'(bus.mem_idx), 32);
    #1 rst_n = 1'b0;
    #1;
    chk("arst mem_we dropped", 32'(bus.mem_we), 0);
    chk("arst dma_ack dropped", 32'(bus.dma_ack), 0);
    @(posedge clk);
    #1;
    chk("arst mem[32] unchanged", mem[32], 32'h0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got %0d checks expected completion", checks);
    $fatal(1);
  end

endmodule
